// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-access stage between EX and WB.
// Loads and stores run as byte-serial transactions on an 8-bit req/ack
// port. The pipeline is held with stallreq until the access completes.
// Optional feature macro: MEM_ALIGN_CHECK_EN. When it is defined, a
// misaligned access is rejected without bus traffic and flagged on misalign.
// Opcode encodings follow defines.v (AluOpBus is 8 bits wide).
module mem_access_unit #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_i,
   input  logic [7:0]        aluop_i,
   input  logic [31:0]       mem_addr_i,
   input  logic [31:0]       store_data_i,
   input  logic [4:0]        reg_waddr_i,
   input  logic              we_i,
   input  logic [31:0]       reg_wdata_i,
   output logic [4:0]        reg_waddr_o,
   output logic              we_o,
   output logic [31:0]       reg_wdata_o,
   output logic              stallreq,
   output logic              misalign,
   output logic              bus_req,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [7:0]        bus_wdata,
   input  logic [7:0]        bus_rdata,
   input  logic              bus_ack
);

   localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
   localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
   localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
   localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
   localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
   localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
   localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
   localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

   typedef enum logic [1:0] {
      S_IDLE,
      S_XFER,
      S_DONE
   } state_t;

   function automatic logic is_load(input logic [7:0] op);
      return (op == EXE_LB_OP) || (op == EXE_LH_OP) || (op == EXE_LW_OP) ||
             (op == EXE_LBU_OP) || (op == EXE_LHU_OP);
   endfunction

   function automatic logic is_store(input logic [7:0] op);
      return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
   endfunction

   // Index of the last byte of the access (size minus one).
   function automatic logic [1:0] last_idx(input logic [7:0] op);
      logic [1:0] r;
      case (op)
         EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: r = 2'd1;
         EXE_LW_OP, EXE_SW_OP:             r = 2'd3;
         default:                          r = 2'd0;
      endcase
      return r;
   endfunction

`ifdef MEM_ALIGN_CHECK_EN
   function automatic logic is_misaligned(input logic [7:0] op, input logic [1:0] a);
      logic r;
      case (op)
         EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: r = a[0];
         EXE_LW_OP, EXE_SW_OP:             r = (a != 2'b00);
         default:                          r = 1'b0;
      endcase
      return r;
   endfunction
`endif

   state_t              state_reg, state_next;
   logic [7:0]          op_reg, op_next;
   logic [ADDR_W-1:0]   base_reg, base_next;
   logic [31:0]         sdata_reg, sdata_next;
   logic [4:0]          waddr_reg, waddr_next;
   logic                we_reg, we_next;
   logic [1:0]          idx_reg, idx_next;
   logic [31:0]         buf_reg, buf_next;
   logic                mis_reg, mis_next;
   logic [31:0]         load_ext;

   // Sign/zero extension of the assembled load buffer.
   always_comb begin
      load_ext = buf_reg;
      case (op_reg)
         EXE_LB_OP:  load_ext = {{24{buf_reg[7]}}, buf_reg[7:0]};
         EXE_LBU_OP: load_ext = {24'd0, buf_reg[7:0]};
         EXE_LH_OP:  load_ext = {{16{buf_reg[15]}}, buf_reg[15:0]};
         EXE_LHU_OP: load_ext = {16'd0, buf_reg[15:0]};
         default:    load_ext = buf_reg;
      endcase
   end

   // State and captured-operand registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= S_IDLE;
         op_reg    <= '0;
         base_reg  <= '0;
         sdata_reg <= '0;
         waddr_reg <= '0;
         we_reg    <= 1'b0;
         idx_reg   <= '0;
         buf_reg   <= '0;
         mis_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         op_reg    <= op_next;
         base_reg  <= base_next;
         sdata_reg <= sdata_next;
         waddr_reg <= waddr_next;
         we_reg    <= we_next;
         idx_reg   <= idx_next;
         buf_reg   <= buf_next;
         mis_reg   <= mis_next;
      end
   end

   // Next-state logic and all outputs; reset forces every output low.
   always_comb begin
      state_next  = state_reg;
      op_next     = op_reg;
      base_next   = base_reg;
      sdata_next  = sdata_reg;
      waddr_next  = waddr_reg;
      we_next     = we_reg;
      idx_next    = idx_reg;
      buf_next    = buf_reg;
      mis_next    = mis_reg;
      reg_waddr_o = reg_waddr_i;
      we_o        = we_i;
      reg_wdata_o = reg_wdata_i;
      stallreq    = 1'b0;
      misalign    = 1'b0;
      bus_req     = 1'b0;
      bus_we      = 1'b0;
      bus_addr    = '0;
      bus_wdata   = '0;

      case (state_reg)
         S_IDLE: begin
            if (valid_i && (is_load(aluop_i) || is_store(aluop_i))) begin
               stallreq   = 1'b1;
               we_o       = 1'b0;
               op_next    = aluop_i;
               base_next  = ADDR_W'(mem_addr_i);
               sdata_next = store_data_i;
               waddr_next = reg_waddr_i;
               we_next    = we_i;
               idx_next   = '0;
               buf_next   = '0;
               mis_next   = 1'b0;
               state_next = S_XFER;
`ifdef MEM_ALIGN_CHECK_EN
               if (is_misaligned(aluop_i, mem_addr_i[1:0])) begin
                  mis_next   = 1'b1;
                  state_next = S_DONE;
               end
`endif
            end
         end

         S_XFER: begin
            stallreq    = 1'b1;
            we_o        = 1'b0;
            reg_waddr_o = waddr_reg;
            reg_wdata_o = '0;
            bus_req     = 1'b1;
            bus_we      = is_store(op_reg);
            bus_addr    = base_reg + ADDR_W'(idx_reg);
            bus_wdata   = sdata_reg[8*idx_reg +: 8];
            if (bus_ack) begin
               if (is_load(op_reg))
                  buf_next[8*idx_reg +: 8] = bus_rdata;
               if (idx_reg == last_idx(op_reg))
                  state_next = S_DONE;
               else
                  idx_next = idx_reg + 2'd1;
            end
         end

         S_DONE: begin
            reg_waddr_o = waddr_reg;
            if (is_load(op_reg) && !mis_reg) begin
               we_o        = we_reg;
               reg_wdata_o = load_ext;
            end else begin
               we_o        = 1'b0;
               reg_wdata_o = '0;
            end
`ifdef MEM_ALIGN_CHECK_EN
            misalign = mis_reg;
`endif
            state_next = S_IDLE;
         end

         default: state_next = S_IDLE;
      endcase

      if (rst) begin
         reg_waddr_o = '0;
         we_o        = 1'b0;
         reg_wdata_o = '0;
         stallreq    = 1'b0;
         misalign    = 1'b0;
         bus_req     = 1'b0;
         bus_we      = 1'b0;
         bus_addr    = '0;
         bus_wdata   = '0;
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: directed scenarios plus randomized
// instruction stream, scoreboarded against a byte-array memory model.
module tb_mem_access_unit;

   localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
   localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
   localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
   localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
   localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
   localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
   localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
   localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;
   localparam logic [7:0] EXE_ADD_OP = 8'b0010_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_i;
   logic [7:0]  aluop_i;
   logic [31:0] mem_addr_i, store_data_i, reg_wdata_i;
   logic [4:0]  reg_waddr_i;
   logic        we_i;
   logic [4:0]  reg_waddr_o;
   logic        we_o;
   logic [31:0] reg_wdata_o;
   logic        stallreq, misalign;
   logic        bus_req, bus_we;
   logic [31:0] bus_addr;
   logic [7:0]  bus_wdata;
   logic [7:0]  bus_rdata = 8'h00;
   logic        bus_ack = 1'b0;

   always #5 clk = ~clk;

   mem_access_unit dut (
      .clk(clk), .rst(rst), .valid_i(valid_i), .aluop_i(aluop_i),
      .mem_addr_i(mem_addr_i), .store_data_i(store_data_i),
      .reg_waddr_i(reg_waddr_i), .we_i(we_i), .reg_wdata_i(reg_wdata_i),
      .reg_waddr_o(reg_waddr_o), .we_o(we_o), .reg_wdata_o(reg_wdata_o),
      .stallreq(stallreq), .misalign(misalign),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
   );

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [7:0]  wdata;
   } bus_exp_t;

   typedef struct {
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic        chk_data;
      logic        mis;
   } wb_exp_t;

   bus_exp_t bus_q[$];
   wb_exp_t  wb_q[$];
   logic [7:0] dev_mem[logic [31:0]];
   logic [7:0] ref_mem[logic [31:0]];
   int n_checks = 0;
   int n_fail   = 0;
   int ack_delay = 0;
   int ack_count = 0;

   function automatic logic [7:0] init_byte(input logic [31:0] a);
      logic [7:0] r;
      r = (a[7:0] * 8'd37) ^ a[15:8] ^ 8'h5A;
      return r;
   endfunction

   function automatic logic [7:0] dev_rd(input logic [31:0] a);
      if (dev_mem.exists(a)) return dev_mem[a];
      return init_byte(a);
   endfunction

   function automatic logic [7:0] ref_rd(input logic [31:0] a);
      if (ref_mem.exists(a)) return ref_mem[a];
      return init_byte(a);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic set_mem(input logic [31:0] a, input logic [7:0] d);
      dev_mem[a] = d;
      ref_mem[a] = d;
   endtask

   // Memory device: acks each byte after ack_delay wait cycles.
   int wcnt = 0;
   always @(negedge clk) begin
      if (rst || !bus_req) begin
         bus_ack = 1'b0;
         wcnt = 0;
      end else begin
         if (bus_ack) wcnt = 0;
         if (wcnt >= ack_delay) begin
            bus_ack = 1'b1;
            ack_count++;
            if (bus_we) dev_mem[bus_addr] = bus_wdata;
            bus_rdata = dev_rd(bus_addr);
         end else begin
            bus_ack = 1'b0;
            bus_rdata = 8'($urandom);
            wcnt++;
         end
      end
   end

   // Monitor: compares bus transfers and WB retirements against the queues.
   logic        prev_req = 1'b0, prev_ack = 1'b0;
   logic [31:0] prev_addr = '0;
   logic [7:0]  prev_wdata = '0;
   always begin
      @(negedge clk);
      #1;
      if (rst) begin
         check("rst_bus_req", 32'(bus_req), 0);
         check("rst_bus_we", 32'(bus_we), 0);
         check("rst_bus_addr", bus_addr, 0);
         check("rst_bus_wdata", 32'(bus_wdata), 0);
         check("rst_stallreq", 32'(stallreq), 0);
         check("rst_we_o", 32'(we_o), 0);
         check("rst_wdata_o", reg_wdata_o, 0);
         check("rst_waddr_o", 32'(reg_waddr_o), 0);
         check("rst_misalign", 32'(misalign), 0);
         prev_req = 1'b0;
         prev_ack = 1'b0;
      end else begin
         if (bus_req && prev_req && !prev_ack) begin
            check("addr_stable", bus_addr, prev_addr);
            check("wdata_stable", 32'(bus_wdata), 32'(prev_wdata));
         end
         if (!stallreq) check("bus_idle", 32'(bus_req), 0);
         if (bus_req && bus_ack) begin
            if (bus_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL bus_unexpected: got addr %h expected no transfer", bus_addr);
            end else begin
               bus_exp_t e;
               e = bus_q.pop_front();
               check("bus_addr", bus_addr, e.addr);
               check("bus_we", 32'(bus_we), 32'(e.we));
               if (e.we) check("bus_wdata", 32'(bus_wdata), 32'(e.wdata));
            end
         end
         if (valid_i && !stallreq) begin
            if (wb_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL wb_unexpected: got retire we_o=%0b expected none", we_o);
            end else begin
               wb_exp_t w;
               w = wb_q.pop_front();
               check("we_o", 32'(we_o), 32'(w.we));
               check("misalign", 32'(misalign), 32'(w.mis));
               if (w.chk_data) begin
                  check("reg_waddr_o", 32'(reg_waddr_o), 32'(w.waddr));
                  check("reg_wdata_o", reg_wdata_o, w.wdata);
               end
            end
         end
         prev_req   = bus_req;
         prev_ack   = bus_ack;
         prev_addr  = bus_addr;
         prev_wdata = bus_wdata;
      end
   end

   function automatic int op_size(input logic [7:0] op);
      case (op)
         EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: return 1;
         EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: return 2;
         EXE_LW_OP, EXE_SW_OP:             return 4;
         default:                          return 0;
      endcase
   endfunction

   // Builds expectations from the reference memory, drives one instruction
   // and checks its latency from issue to retirement.
   task automatic issue(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                        input logic [4:0] waddr, input logic we, input logic [31:0] alu, input int d);
      int n, cyc, exp_cyc;
      logic is_st, mis;
      logic [31:0] val;
      wb_exp_t w;
      bus_exp_t b;
      @(posedge clk);
      #1;
      valid_i = 1'b1; aluop_i = op; mem_addr_i = addr; store_data_i = sdata;
      reg_waddr_i = waddr; we_i = we; reg_wdata_i = alu; ack_delay = d;
      n = op_size(op);
      is_st = (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
      mis = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      mis = (n == 2 && addr[0]) || (n == 4 && addr[1:0] != 2'b00);
`endif
      if (n == 0) begin
         w = '{we, waddr, alu, 1'b1, 1'b0};
         exp_cyc = 1;
      end else if (mis) begin
         w = '{1'b0, waddr, 32'd0, 1'b0, 1'b1};
         exp_cyc = 2;
      end else begin
         val = 32'd0;
         for (int i = 0; i < n; i++) begin
            b.addr = addr + 32'(i);
            b.we = is_st;
            b.wdata = sdata[8*i +: 8];
            bus_q.push_back(b);
            if (is_st) ref_mem[b.addr] = b.wdata;
            else val[8*i +: 8] = ref_rd(b.addr);
         end
         case (op)
            EXE_LB_OP: val = {{24{val[7]}}, val[7:0]};
            EXE_LH_OP: val = {{16{val[15]}}, val[15:0]};
            default:   val = val;
         endcase
         if (is_st) w = '{1'b0, waddr, 32'd0, 1'b0, 1'b0};
         else       w = '{we, waddr, val, 1'b1, 1'b0};
         exp_cyc = 2 + n * (1 + d);
      end
      wb_q.push_back(w);
      cyc = 0;
      do begin
         @(negedge clk);
         #2;
         cyc++;
      end while (stallreq && cyc < 500);
      check("latency", 32'(cyc), 32'(exp_cyc));
      $display("op=%h addr=%h data=%h delay=%0d cycles=%0d", op, addr, sdata, d, cyc);
   endtask

   task automatic bubble();
      @(posedge clk);
      #1;
      valid_i = 1'b0;
      aluop_i = 8'($urandom);
      we_i = 1'($urandom);
   endtask

   logic [7:0] mem_ops [8] = '{EXE_LB_OP, EXE_LH_OP, EXE_LW_OP, EXE_LBU_OP,
                               EXE_LHU_OP, EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int start;
      int guard;
      logic [7:0] op;
      logic [31:0] addr;
      // Reset with a memory op presented: every output must stay low.
      rst = 1'b1; valid_i = 1'b1; aluop_i = EXE_LW_OP; mem_addr_i = 32'h100;
      store_data_i = $urandom; reg_waddr_i = 5'd7; we_i = 1'b1; reg_wdata_i = $urandom;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0; valid_i = 1'b0;

      set_mem(32'h100, 8'h78); set_mem(32'h101, 8'h56);
      set_mem(32'h102, 8'h34); set_mem(32'h103, 8'h12);
      issue(EXE_LW_OP, 32'h100, 32'h0, 5'd1, 1'b1, 32'h0, 0);
      set_mem(32'h3, 8'h80);
      issue(EXE_LB_OP, 32'h3, 32'h0, 5'd2, 1'b1, 32'h0, 0);
      issue(EXE_LBU_OP, 32'h3, 32'h0, 5'd3, 1'b1, 32'h0, 0);
      set_mem(32'h40, 8'h01); set_mem(32'h41, 8'h80);
      issue(EXE_LH_OP, 32'h40, 32'h0, 5'd4, 1'b1, 32'h0, 1);
      issue(EXE_SH_OP, 32'h2, 32'hDEADBEEF, 5'd5, 1'b1, 32'h0, 0);
      issue(EXE_LHU_OP, 32'h2, 32'h0, 5'd6, 1'b1, 32'h0, 0);
      issue(EXE_SW_OP, 32'h20, 32'hCAFEF00D, 5'd7, 1'b0, 32'h0, 3);
      issue(EXE_LW_OP, 32'h20, 32'h0, 5'd8, 1'b1, 32'h0, 2);

      // Reset in the middle of a load after two bytes have been acked.
      @(posedge clk);
      #1;
      valid_i = 1'b1; aluop_i = EXE_LW_OP; mem_addr_i = 32'h80; we_i = 1'b1;
      reg_waddr_i = 5'd9; ack_delay = 1;
      for (int i = 0; i < 4; i++) bus_q.push_back('{32'h80 + 32'(i), 1'b0, 8'h00});
      wb_q.push_back('{1'b1, 5'd9, 32'h0, 1'b0, 1'b0});
      start = ack_count;
      guard = 0;
      while (ack_count < start + 2 && guard < 100) begin
         @(negedge clk);
         #2;
         guard++;
      end
      check("rst_wait_acks", 32'(ack_count - start), 2);
      @(posedge clk);
      #1;
      rst = 1'b1; valid_i = 1'b0; we_i = 1'b0;
      bus_q.delete();
      wb_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      #2;
      check("post_rst_stallreq", 32'(stallreq), 0);
      check("post_rst_bus_req", 32'(bus_req), 0);
      check("post_rst_we_o", 32'(we_o), 0);
      issue(EXE_ADD_OP, 32'h0, 32'h0, 5'd10, 1'b1, 32'h13572468, 0);

      issue(EXE_LW_OP, 32'h101, 32'h0, 5'd11, 1'b1, 32'h0, 0);
      issue(EXE_LW_OP, 32'hFFFFFFFE, 32'h0, 5'd12, 1'b1, 32'h0, 0);
      issue(EXE_SW_OP, 32'hFFFFFFFD, 32'h11223344, 5'd13, 1'b0, 32'h0, 1);

      for (int k = 0; k < 300; k++) begin
         if ($urandom_range(0, 4) == 0) bubble();
         if ($urandom_range(0, 9) < 2) begin
            do op = 8'($urandom); while (op_size(op) != 0);
         end else begin
            op = mem_ops[$urandom_range(0, 7)];
         end
         if ($urandom_range(0, 9) == 0) addr = 32'hFFFFFFF8 + 32'($urandom_range(0, 7));
         else addr = 32'($urandom_range(0, 63));
         issue(op, addr, $urandom, 5'($urandom), 1'($urandom), $urandom, $urandom_range(0, 2));
      end
      bubble();
      @(negedge clk);
      #2;
      check("bus_q_drained", 32'(bus_q.size()), 0);
      check("wb_q_drained", 32'(wb_q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
